instruction_queue: RTL

Parametrised successor to the single-stage instruction register: a DEPTH-entry prefetch FIFO in front of an instruction register (IR). Fetch logic pushes instruction words with a valid/ready handshake. The control unit pops the head into the IR with `load_ir`, and the IR is presented as split opcode and operand fields. A synchronous `flush` discards prefetched words on branches.

---
 rtl/instruction_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/instruction_queue.sv
// Prefetch FIFO feeding an instruction register.
// IR is split into opcode and operand fields.
module instruction_queue #(
  parameter int INSTR_W  = 8,
  parameter int OPCODE_W = 4,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [INSTR_W-1:0]          in_instr,
  output logic                        in_ready,
  input  logic                        load_ir,
  output logic [OPCODE_W-1:0]         opcode,
  output logic [INSTR_W-OPCODE_W-1:0] data_out,
  output logic                        ir_valid,
  output logic [CNT_W-1:0]            count,
  output logic                        empty,
  output logic                        full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic               full_w, empty_w;
  logic               push, pop;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CNT_W'(DEPTH));

  // A word offered during flush is dropped.
  assign push = in_valid && !full_w && !flush;
  assign pop  = load_ir && !empty_w && !flush;

  // Next-state: flush dominates, then push/pop.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      ir_valid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        ir_d       = mem_q[rd_ptr_q];
        ir_valid_d = 1'b1;
      end else if (load_ir) begin
        ir_valid_d = 1'b0;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state and IR registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_instr;
    end
  end

  assign in_ready = !full_w;
  assign full     = full_w;
  assign empty    = empty_w;
  assign count    = count_q;
  assign ir_valid = ir_valid_q;
  assign opcode   = ir_q[INSTR_W-1 -: OPCODE_W];
  assign data_out = ir_q[INSTR_W-OPCODE_W-1:0];

endmodule
